fetch_unit: RTL
===============

# fetch_unit

Instruction fetch and sequencing unit for the 9-bit single-cycle core. It owns the program counter, the page register and run/halt state. It addresses the synchronous instruction ROM and presents each fetched instruction, with its `init` qualifier, to the decode/control block. In the same cycle it consumes the control block's `branch`, `incrementPage` and `decrementPage` decisions to choose the next PC and page.

## Interface
Parameters:
- `PC_W`, 10, program counter / ROM address width.
- `PAGE_W`, 2, page register width.
- `PC_START`, 0, PC loaded on start.
- `HALT_INSTR`, 9'h1FF, encoding that stops execution.
- `CNT_W`, 16, retired-instruction counter width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin execution from `PC_START`.
- `imem_addr`  out  PC_W  ROM read address (combinational next PC).
- `imem_rdata`  in  9  ROM data, valid one cycle after `imem_addr`.
- `instruction`  out  9  instruction to control block.
- `ctrl_init`  out  1  drives control block `init`; 1 = no instruction to execute.
- `branch`  in  1  control block branch signal.
- `branch_taken`  in  1  datapath branch condition.
- `branch_target`  in  PC_W  absolute branch destination.
- `increment_page`, `decrement_page`  in  1 each  control block page commands.
- `pc`  out  PC_W  current PC.
- `page`  out  PAGE_W  current page.
- `done`  out  1  program halted.
- `retired`  out  CNT_W  count of executed instructions.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, `pc`=PC_START, `page`=0, `done`=0, `retired`=0. `ctrl_init`=1 and `instruction`=0 while not in RUN.
- IDLE: `imem_addr`=PC_START. When `start`=1: `pc`<=PC_START, `page`<=0, `retired`<=0, go to RUN.
- RUN: `instruction`=`imem_rdata` (combinational). `ctrl_init`=0 unless `instruction`==HALT_INSTR.
  - Next PC: if `branch` and `branch_taken`, it is `branch_target`. Otherwise it is `pc`+1, wrapping modulo 2^PC_W.
  - `imem_addr` = next PC. `pc` loads next PC at the edge.
  - `page`: +1 on `increment_page`, −1 on `decrement_page`. It saturates at 2^PAGE_W−1 and at 0. If both are asserted, `page` holds.
  - `retired` increments by 1 per non-halt RUN cycle and saturates at all-ones.
- HALT: if `instruction`==HALT_INSTR in RUN:
  - `ctrl_init`=1 that cycle, so no write, branch or page effect occurs.
  - `pc`, `page` and `retired` hold.
  - Next state is DONE.
- DONE: `done`=1, `ctrl_init`=1, `imem_addr`=PC_START, and `pc`/`page`/`retired` hold. `start` restarts exactly as from IDLE and clears `done`.
- `start` is ignored in RUN.
- `reset` has priority over everything, including `start`, in any state, mid-program included.

## Timing
- Cycle n: IDLE with `start`=1. Cycle n+1: RUN, `pc`=PC_START, `instruction`=ROM[PC_START], `ctrl_init`=0.
- Throughput: one instruction per cycle, with no bubble on taken branches. A taken branch in cycle k gives `instruction`=ROM[target] in cycle k+1.
- Page changes are visible on `page` in the cycle after the command.
- HALT fetched in cycle h: `ctrl_init`=1 combinationally in cycle h. `done`=1 from cycle h+1.
- `reset` asserted in cycle r: outputs hold their reset values from cycle r+1.

## Test plan
- ROM[0..3]=four ADD ops, ROM[4]=HALT, then start:
  - `instruction` follows ROM[0..4] over cycles 1–5.
  - `ctrl_init`=1 in cycle 5.
  - `done`=1 from cycle 6.
  - `retired`=4, `pc`=4.
- Branch at pc=2 with target 7:
  - `branch_taken`=1: next `instruction`=ROM[7].
  - `branch_taken`=0: next `instruction`=ROM[3].
  - `retired` matches the path taken.
- Page saturation:
  - Five consecutive `increment_page` pulses give `page`=3.
  - Then five `decrement_page` pulses give `page`=0.
  - Both asserted together: `page` unchanged.
- PC wrap: ROM[1023]=ADD, branch to 1023 → next `pc`=0 and `instruction`=ROM[0].
- Reset mid-run at pc=5, page=2: next cycle `pc`=0, `page`=0, `ctrl_init`=1, state IDLE. A later `start` runs from ROM[0].
- Restart from DONE: `start` → `done`=0, `retired`=0, `page`=0, and `instruction`=ROM[0] in the next cycle. `start` pulsed during RUN has no effect.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch and sequencing unit for the 9-bit single-cycle core.
// Owns the program counter, the page register and the IDLE/RUN/DONE
// execution state. It addresses a synchronous instruction ROM (data returns
// one cycle after the address) and hands each fetched instruction, with its
// init qualifier, to the decode/control block. The control block's branch
// and page decisions for the current instruction are folded into the next
// PC and page in the same cycle, so fetch runs at one instruction per cycle
// with no bubble on taken branches.
//
// Ports:
//   clk            in   1       sole clock, rising edge
//   reset          in   1       synchronous active-high reset
//   start          in   1       begin execution from PC_START (IDLE/DONE only)
//   imem_addr      out  PC_W    ROM read address (combinational next PC)
//   imem_rdata     in   9       ROM data, valid one cycle after imem_addr
//   instruction    out  9       instruction to control block (0 outside RUN)
//   ctrl_init      out  1       1 = no instruction to execute this cycle
//   branch         in   1       control block branch request
//   branch_taken   in   1       datapath branch condition
//   branch_target  in   PC_W    absolute branch destination
//   increment_page in   1       page +1 (saturating)
//   decrement_page in   1       page -1 (saturating)
//   pc             out  PC_W    current PC
//   page           out  PAGE_W  current page
//   done           out  1       program halted
//   retired        out  CNT_W   executed-instruction count (saturating)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned     PC_W       = 10,
    parameter int unsigned     PAGE_W     = 2,
    parameter logic [PC_W-1:0] PC_START   = '0,
    parameter logic [8:0]      HALT_INSTR = 9'h1FF,
    parameter int unsigned     CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [8:0]        imem_rdata,
    output logic [8:0]        instruction,
    output logic              ctrl_init,
    input  logic              branch,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              increment_page,
    input  logic              decrement_page,
    output logic [PC_W-1:0]   pc,
    output logic [PAGE_W-1:0] page,
    output logic              done,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [PAGE_W-1:0] PAGE_MAX = {PAGE_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_t              state_r;
    state_t              state_next_s;

    logic [PC_W-1:0]     pc_r;
    logic [PC_W-1:0]     pc_next_s;
    logic [PC_W-1:0]     pc_seq_s;
    logic [PAGE_W-1:0]   page_r;
    logic [PAGE_W-1:0]   page_next_s;
    logic [CNT_W-1:0]    retired_r;
    logic [CNT_W-1:0]    retired_next_s;
    logic                done_r;
    logic                done_next_s;

    logic                in_run_s;
    logic                is_halt_s;
    logic                exec_s;
    logic                launch_s;
    logic                branch_go_s;

    logic [PC_W-1:0]     imem_addr_s;
    logic [8:0]          instruction_s;
    logic                ctrl_init_s;

    // Saturating page step: +1 / -1 only when exactly one command is active.
    function automatic logic [PAGE_W-1:0] page_step(
        input logic [PAGE_W-1:0] cur,
        input logic              inc,
        input logic              dec
    );
        logic [PAGE_W-1:0] res;
        res = cur;
        if (inc && !dec && (cur != PAGE_MAX)) begin
            res = cur + {{(PAGE_W-1){1'b0}}, 1'b1};
        end else if (dec && !inc && (cur != {PAGE_W{1'b0}})) begin
            res = cur - {{(PAGE_W-1){1'b0}}, 1'b1};
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // Saturating retired-instruction count increment.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cur);
        logic [CNT_W-1:0] res;
        if (cur != CNT_MAX) begin
            res = cur + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // Execution qualifiers shared by the next-state, datapath and output logic.
    always_comb begin
        in_run_s    = (state_r == ST_RUN);
        // A halt word only counts while actually running; outside RUN the ROM
        // output is stale and must not be decoded.
        is_halt_s   = in_run_s && (imem_rdata == HALT_INSTR);
        exec_s      = in_run_s && !is_halt_s;
        launch_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        branch_go_s = exec_s && branch && branch_taken;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (is_halt_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next PC / page / count / done. The halt cycle behaves like a held cycle:
    // no branch, no page change and no retirement.
    always_comb begin
        pc_seq_s       = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        pc_next_s      = pc_r;
        page_next_s    = page_r;
        retired_next_s = retired_r;
        done_next_s    = done_r;
        if (launch_s) begin
            pc_next_s      = PC_START;
            page_next_s    = {PAGE_W{1'b0}};
            retired_next_s = {CNT_W{1'b0}};
            done_next_s    = 1'b0;
        end else if (exec_s) begin
            if (branch_go_s) begin
                pc_next_s = branch_target;
            end else begin
                pc_next_s = pc_seq_s;
            end
            page_next_s    = page_step(page_r, increment_page, decrement_page);
            retired_next_s = cnt_step(retired_r);
            done_next_s    = done_r;
        end else if (is_halt_s) begin
            pc_next_s      = pc_r;
            page_next_s    = page_r;
            retired_next_s = retired_r;
            done_next_s    = 1'b1;
        end else begin
            pc_next_s      = pc_r;
            page_next_s    = page_r;
            retired_next_s = retired_r;
            done_next_s    = done_r;
        end
    end

    // Architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r      <= PC_START;
            page_r    <= {PAGE_W{1'b0}};
            retired_r <= {CNT_W{1'b0}};
            done_r    <= 1'b0;
        end else begin
            pc_r      <= pc_next_s;
            page_r    <= page_next_s;
            retired_r <= retired_next_s;
            done_r    <= done_next_s;
        end
    end

    // Output logic. The ROM is addressed with the next PC so its registered
    // data lines up with pc in the following cycle; outside RUN it is parked
    // on PC_START so a start from IDLE or DONE finds ROM[PC_START] ready.
    always_comb begin
        imem_addr_s   = PC_START;
        instruction_s = 9'd0;
        ctrl_init_s   = 1'b1;
        case (state_r)
            ST_RUN: begin
                imem_addr_s   = pc_next_s;
                instruction_s = imem_rdata;
                ctrl_init_s   = is_halt_s;
            end
            ST_IDLE, ST_DONE: begin
                imem_addr_s   = PC_START;
                instruction_s = 9'd0;
                ctrl_init_s   = 1'b1;
            end
            default: begin
                imem_addr_s   = PC_START;
                instruction_s = 9'd0;
                ctrl_init_s   = 1'b1;
            end
        endcase
    end

    assign imem_addr   = imem_addr_s;
    assign instruction = instruction_s;
    assign ctrl_init   = ctrl_init_s;
    assign pc          = pc_r;
    assign page        = page_r;
    assign done        = done_r;
    assign retired     = retired_r;

endmodule
